// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } lsu_state_t;

    localparam int FLAG_OFS = 0;
    localparam int VAL_OFS  = 1;

    localparam logic [15:0] MMIO_BASE_DEF = 16'hFFFE;

endpackage

// File: rtl/player_input_reg.sv
// Player-input flag/value holding register; a set on the same edge as a
// clear wins so an event arriving during a read-and-clear is never lost.
module player_input_reg
    import lsu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set,
    input  logic [WIDTH-1:0] set_val,
    input  logic             clr,
    output logic             flag,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag  <= 1'b0;
            value <= '0;
        end else if (set) begin
            flag  <= 1'b1;
            value <= set_val;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the synchronous-read data RAM. Define LSU_MMIO_EN
// to add the two-word player-input window at MMIO_BASE.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int                       WIDTH         = 16,
    parameter int                       RAM_ADDR_BITS = 16,
    parameter logic [RAM_ADDR_BITS-1:0] MMIO_BASE     = MMIO_BASE_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [RAM_ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     ready,
    output logic                     done,
    output logic [WIDTH-1:0]         rdata,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_writedata,
    input  logic [WIDTH-1:0]         mem_data,
    input  logic                     player_strobe,
    input  logic [WIDTH-1:0]         player_val
);

    lsu_state_t       state, state_nxt;
    logic             accept;
    logic             done_nxt;
    logic             is_mmio;
    logic             load_q;
    logic             mmio_q;
    logic [WIDTH-1:0] mmio_rdata;

    assign accept = req && ready;

`ifdef LSU_MMIO_EN
    logic [RAM_ADDR_BITS:0] addr_x, base_x;
    logic                   hit_flag, hit_val;
    logic                   ofs_q;
    logic                   flag_clr;
    logic                   flag;
    logic [WIDTH-1:0]       value;

    // Compare one bit wider so a base at the top of the space cannot wrap to 0.
    assign addr_x   = {1'b0, addr};
    assign base_x   = {1'b0, MMIO_BASE};
    assign hit_flag = (addr_x == base_x + (RAM_ADDR_BITS+1)'(FLAG_OFS));
    assign hit_val  = (addr_x == base_x + (RAM_ADDR_BITS+1)'(VAL_OFS));
    assign is_mmio  = hit_flag || hit_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ofs_q <= 1'b0;
        else if (accept)
            ofs_q <= hit_val;
    end

    // Reading the value or writing the flag word acknowledges the event.
    assign flag_clr   = (state == ISSUE) && mmio_q && (load_q ? ofs_q : !ofs_q);
    assign mmio_rdata = ofs_q ? value : {{(WIDTH-1){1'b0}}, flag};

    player_input_reg #(
        .WIDTH (WIDTH)
    ) u_player (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (player_strobe),
        .set_val (player_val),
        .clr     (flag_clr),
        .flag    (flag),
        .value   (value)
    );
`else
    logic unused_player;

    assign is_mmio       = 1'b0;
    assign mmio_rdata    = '0;
    assign unused_player = ^{player_strobe, player_val};
`endif

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (load_q && !mmio_q) begin
                    state_nxt = RD_WAIT;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            RD_WAIT: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            rdata         <= '0;
            mem_en        <= 1'b0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_adr       <= '0;
            mem_writedata <= '0;
            load_q        <= 1'b0;
            mmio_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept) begin
                load_q <= !we;
                mmio_q <= is_mmio;
                if (!is_mmio) begin
                    mem_en        <= 1'b1;
                    mem_write     <= we;
                    mem_read      <= !we;
                    mem_adr       <= addr;
                    mem_writedata <= wdata;
                end
            end
            // RAM strobes last exactly the ISSUE cycle; address/data are left held.
            if (state == ISSUE) begin
                mem_en    <= 1'b0;
                mem_write <= 1'b0;
                mem_read  <= 1'b0;
                if (mmio_q && load_q)
                    rdata <= mmio_rdata;
            end
            if (state == RD_WAIT)
                rdata <= mem_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: load results are queued at issue and
// compared when done pulses; timing and RAM strobes are checked per request.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic        mem_en, mem_write, mem_read;
    logic [15:0] mem_adr;
    logic [15:0] mem_writedata;
    logic [15:0] mem_data;
    logic        player_strobe = 1'b0;
    logic [15:0] player_val = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ram [0:65535];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .WIDTH         (16),
        .RAM_ADDR_BITS (16),
        .MMIO_BASE     (16'hFFFE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .ready         (ready),
        .done          (done),
        .rdata         (rdata),
        .mem_en        (mem_en),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_adr       (mem_adr),
        .mem_writedata (mem_writedata),
        .mem_data      (mem_data),
        .player_strobe (player_strobe),
        .player_val    (player_val)
    );

    // Synchronous-read RAM: registered read data one edge after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) ram[mem_adr] <= mem_writedata;
            if (mem_read)  mem_data     <= ram[mem_adr];
        end
    end

    task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit to_ram, input logic [15:0] expv, input string tag);
        int waitc = 0;
        int lat = -1;
        int en_cnt = 0;
        int want_lat;
        logic [15:0] e;
        want_lat = (to_ram && !w) ? 2 : 1;
        while (ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_timeout: ready=%b want 1", tag, ready);
            return;
        end
        if (!w) exp_q.push_back(expv);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 0; k < 6 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                en_cnt++;
                vectors++;
                if (k != 0 || mem_write !== w || mem_read !== !w || mem_adr !== a ||
                    (w && mem_writedata !== d)) begin
                    miscompares++;
                    $display("FAIL %s mem_ctl: k=%0d w=%b r=%b adr=%h wd=%h want k=0 w=%b adr=%h wd=%h",
                             tag, k, mem_write, mem_read, mem_adr, mem_writedata, w, a, d);
                end
            end
            if (done === 1'b1) begin
                lat = k;
                vectors++;
                if (ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s ready_at_done: ready=%b want 1", tag, ready);
                end
            end else begin
                vectors++;
                if (ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy_ready: k=%0d ready=%b want 0", tag, k, ready);
                end
            end
        end
        vectors++;
        if (lat != want_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, want_lat);
        end
        vectors++;
        if (en_cnt != (to_ram ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s mem_en_cycles: got %0d want %0d", tag, en_cnt, to_ram ? 1 : 0);
        end
        if (!w) begin
            e = exp_q.pop_front();
            vectors++;
            if (rdata !== e) begin
                miscompares++;
                $display("FAIL %s rdata: got %h want %h", tag, rdata, e);
            end
        end
    endtask

    task automatic pulse_strobe(input logic [15:0] v);
        @(negedge clk);
        player_strobe = 1'b1;
        player_val    = v;
        @(posedge clk);
        #1 player_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: ready=%b done=%b want 1 0", ready, done);
        end
        vectors++;
        if ({mem_en, mem_write, mem_read} !== 3'b000 || mem_adr !== 16'h0 || mem_writedata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mem: en/wr/rd=%b%b%b adr=%h wd=%h want 0", mem_en, mem_write, mem_read,
                     mem_adr, mem_writedata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdata !== 16'h0 || ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: rdata=%h ready=%b done=%b want 0000 1 0", rdata, ready, done);
        end
    endtask

    task automatic test_store_load();
        xfer(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0, "store");
        xfer(1'b0, 16'h0010, 16'h0, 1'b1, 16'hBEEF, "load");
        xfer(1'b1, 16'h0011, 16'h1234, 1'b1, 16'h0, "store2");
        vectors++;
        if (rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rdata_hold: got %h want BEEF", rdata);
        end
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0, "b2b_st0");
        xfer(1'b0, 16'h0020, 16'h0, 1'b1, 16'h1111, "b2b_ld0");
        xfer(1'b1, 16'h0021, 16'h2222, 1'b1, 16'h0, "b2b_st1");
        xfer(1'b1, 16'h0022, 16'h3333, 1'b1, 16'h0, "b2b_st2");
        xfer(1'b0, 16'h0021, 16'h0, 1'b1, 16'h2222, "b2b_ld1");
        xfer(1'b0, 16'h0022, 16'h0, 1'b1, 16'h3333, "b2b_ld2");
    endtask

`ifdef LSU_MMIO_EN
    task automatic test_mmio();
        pulse_strobe(16'h0005);
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0001, "mmio_flag_set");
        xfer(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0005, "mmio_val");
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0000, "mmio_flag_clr");
        pulse_strobe(16'h0007);
        xfer(1'b1, 16'hFFFF, 16'hAAAA, 1'b0, 16'h0, "mmio_st_val");
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0001, "mmio_flag_kept");
        xfer(1'b1, 16'hFFFE, 16'h0, 1'b0, 16'h0, "mmio_st_flag");
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0000, "mmio_flag_stclr");
        xfer(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0007, "mmio_val2");
        xfer(1'b1, 16'hFFFD, 16'h5555, 1'b1, 16'h0, "below_window_st");
        xfer(1'b0, 16'hFFFD, 16'h0, 1'b1, 16'h5555, "below_window_ld");
    endtask

    task automatic test_strobe_clear();
        fork
            xfer(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0007, "sc_old_val");
            begin
                @(posedge clk);
                @(negedge clk);
                player_strobe = 1'b1;
                player_val    = 16'h0009;
                @(posedge clk);
                #1 player_strobe = 1'b0;
            end
        join
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0001, "sc_flag");
        xfer(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0009, "sc_new_val");
    endtask
`else
    task automatic test_window_ram();
        xfer(1'b1, 16'hFFFE, 16'h1234, 1'b1, 16'h0, "win_st0");
        xfer(1'b1, 16'hFFFF, 16'hABCD, 1'b1, 16'h0, "win_st1");
        pulse_strobe(16'h0005);
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b1, 16'h1234, "win_ld0");
        xfer(1'b0, 16'hFFFF, 16'h0, 1'b1, 16'hABCD, "win_ld1");
    endtask
`endif

    task automatic test_reset_mid_load();
        bit saw_done = 1'b0;
        xfer(1'b1, 16'h0030, 16'h5A5A, 1'b1, 16'h0, "rst_prep");
        req = 1'b1; we = 1'b0; addr = 16'h0030;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_en, mem_write, mem_read} !== 3'b000 || mem_adr !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid_mem: en/wr/rd=%b%b%b adr=%h want 000 0000", mem_en, mem_write, mem_read,
                     mem_adr);
        end
        vectors++;
        if (ready !== 1'b1 || rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid_state: ready=%b rdata=%h want 1 0000", ready, rdata);
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL rst_mid_done: done pulse seen=%b want 0", saw_done);
        end
        vectors++;
        if (ready !== 1'b1 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_release: ready=%b mem_en=%b want 1 0", ready, mem_en);
        end
`ifdef LSU_MMIO_EN
        xfer(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h0000, "rst_flag_cleared");
`endif
        xfer(1'b0, 16'h0030, 16'h0, 1'b1, 16'h5A5A, "rst_recover_ld");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
`ifdef LSU_MMIO_EN
        test_mmio();
        test_strobe_clear();
`else
        test_window_ram();
`endif
        test_reset_mid_load();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
